// File: rtl/puf_eval_sequencer.sv
// Initiator for the PDL PUF array: arm, fire, settle, sample, release, then return the response.
// Define PUF_MAJORITY_VOTE_EN to repeat each evaluation VOTES times and return the per-bit majority.
module puf_eval_sequencer #(
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int LOW_CYCLES    = 4,
    parameter int VOTES         = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_challenge,
    input  logic [15:0]  req_a,
    input  logic [15:0]  req_b,
    output logic [127:0] puf_challenge,
    output logic [15:0]  puf_a,
    output logic [15:0]  puf_b,
    output logic         puf_trigger,
    output logic         puf_reset,
    input  logic [15:0]  puf_response,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [15:0]  rsp_data
);

    // state   | meaning
    // IDLE    | req_ready high, waiting for a request
    // ARM     | puf_reset high, trigger low
    // FIRE    | trigger high, race settling; response sampled on exit
    // RELEASE | trigger low before the next vote or the response
    // RESP    | rsp_valid high until the consumer takes it
    typedef enum logic [2:0] {IDLE, ARM, FIRE, RELEASE, RESP} state_t;

    localparam int MAX_AB = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int MAX_P  = (MAX_AB > LOW_CYCLES) ? MAX_AB : LOW_CYCLES;
    localparam int CW     = $clog2(MAX_P + 1);

    if (RST_CYCLES < 1 || SETTLE_CYCLES < 1 || LOW_CYCLES < 1 ||
        VOTES < 1 || VOTES > 15 || (VOTES % 2) == 0) begin : g_bad_params
        $error("puf_eval_sequencer: illegal parameter value");
    end

    state_t        state;
    logic [CW-1:0] cnt;

`ifdef PUF_MAJORITY_VOTE_EN
    logic [3:0]       votes_left;
    logic [15:0][3:0] vcount;
    logic [15:0]      majority;

    always_comb begin
        majority = '0;
        for (int i = 0; i < 16; i++) begin
            majority[i] = (vcount[i] > 4'(VOTES / 2));
        end
    end
`else
    logic [15:0] sample_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            req_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            puf_trigger   <= 1'b0;
            puf_reset     <= 1'b0;
            puf_challenge <= '0;
            puf_a         <= '0;
            puf_b         <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
            votes_left    <= '0;
            vcount        <= '0;
`else
            sample_q      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        puf_challenge <= req_challenge;
                        puf_a         <= req_a;
                        puf_b         <= req_b;
                        req_ready     <= 1'b0;
                        // puf_reset rises on the next edge, so load the full count here
                        cnt           <= CW'(RST_CYCLES);
                        state         <= ARM;
`ifdef PUF_MAJORITY_VOTE_EN
                        votes_left    <= 4'(VOTES - 1);
                        vcount        <= '0;
`endif
                    end
                end
                ARM: begin
                    if (cnt == '0) begin
                        puf_reset   <= 1'b0;
                        puf_trigger <= 1'b1;
                        cnt         <= CW'(SETTLE_CYCLES - 1);
                        state       <= FIRE;
                    end else begin
                        puf_reset <= 1'b1;
                        cnt       <= cnt - CW'(1);
                    end
                end
                FIRE: begin
                    if (cnt == '0) begin
                        puf_trigger <= 1'b0;
                        cnt         <= CW'(LOW_CYCLES - 1);
                        state       <= RELEASE;
`ifdef PUF_MAJORITY_VOTE_EN
                        for (int i = 0; i < 16; i++) begin
                            vcount[i] <= vcount[i] + 4'(puf_response[i]);
                        end
`else
                        sample_q    <= puf_response;
`endif
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RELEASE: begin
                    if (cnt == '0) begin
`ifdef PUF_MAJORITY_VOTE_EN
                        if (votes_left != '0) begin
                            votes_left <= votes_left - 4'd1;
                            puf_reset  <= 1'b1;
                            cnt        <= CW'(RST_CYCLES - 1);
                            state      <= ARM;
                        end else begin
                            rsp_data  <= majority;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
`else
                        rsp_data  <= sample_q;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
`endif
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Bench for puf_eval_sequencer: array model, response scoreboard, vector table and timing sequences.
// Follows PUF_MAJORITY_VOTE_EN so the same bench covers both builds.
module tb_puf_eval_sequencer;

    localparam int RST = 4;
    localparam int SET = 16;
    localparam int LOW = 4;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int NV = 5;
`else
    localparam int NV = 1;
`endif
    localparam int PER = RST + SET + LOW;
    localparam int LAT = 1 + NV * PER;

    logic         clk;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] req_challenge;
    logic [15:0]  req_a;
    logic [15:0]  req_b;
    logic [127:0] puf_challenge;
    logic [15:0]  puf_a;
    logic [15:0]  puf_b;
    logic         puf_trigger;
    logic         puf_reset;
    logic [15:0]  puf_response;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [15:0]  rsp_data;

    puf_eval_sequencer #(
        .RST_CYCLES(RST), .SETTLE_CYCLES(SET), .LOW_CYCLES(LOW), .VOTES(5)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_challenge(req_challenge), .req_a(req_a), .req_b(req_b),
        .puf_challenge(puf_challenge), .puf_a(puf_a), .puf_b(puf_b),
        .puf_trigger(puf_trigger), .puf_reset(puf_reset), .puf_response(puf_response),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    logic [15:0] model_q[$];
    logic [15:0] sb_q[$];
    logic        trig_d = 1'b0;
    int          last_hs = -1;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Array model: presents the current vote value while triggered, noise otherwise.
    always @(negedge clk) begin
        if (trig_d && !puf_trigger && model_q.size() > 0) void'(model_q.pop_front());
        trig_d = puf_trigger;
        if (puf_trigger && model_q.size() > 0) puf_response = model_q[0];
        else puf_response = 16'($urandom);
        if (!reset && rsp_valid && rsp_ready) begin
            last_hs = cyc + 1;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got response %0h with nothing expected", rsp_data);
            end else begin
                chk("rsp_data", 128'(rsp_data), 128'(sb_q.pop_front()));
            end
        end
    end

    task automatic push_single(input logic [15:0] v);
        for (int i = 0; i < NV; i++) model_q.push_back(v);
        sb_q.push_back(v);
    endtask

    task automatic issue(input logic [127:0] ch, input logic [15:0] a, input logic [15:0] b,
                         output int acc);
        int n;
        n = 0;
        req_challenge = ch;
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        while (!req_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready still %0b after %0d cycles", req_ready, n);
        end
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 1'b0;
    endtask

    // Per-cycle phase check from the accept edge through rsp_valid rising.
    task automatic timed(input logic [127:0] ch, input bit inject);
        int p;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk); #1;
            p = (k - 1) % PER;
            chk($sformatf("puf_reset@%0d", k), 128'(puf_reset), 128'(k < LAT && p < RST));
            chk($sformatf("puf_trigger@%0d", k), 128'(puf_trigger),
                128'(k < LAT && p >= RST && p < RST + SET));
            chk($sformatf("rsp_valid@%0d", k), 128'(rsp_valid), 128'(k == LAT));
            chk($sformatf("puf_challenge@%0d", k), puf_challenge, ch);
            chk($sformatf("req_ready@%0d", k), 128'(req_ready), 128'(0));
            if (inject && k == 8) begin
                req_valid = 1'b1;
                req_challenge = ~ch;
            end else begin
                req_valid = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic [127:0] ch;
        logic [15:0]  a;
        logic [15:0]  b;
        logic [15:0]  resp;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int acc;
        int n;
        logic [127:0] ch1;
        logic [127:0] ch2;

        tbl[0] = '{128'hFEDCBA98765432100011223344556677, 16'h0001, 16'h0002, 16'h0001};
        tbl[1] = '{128'h00000000000000000000000000000001, 16'hFFFF, 16'h0000, 16'hFFFE};
        tbl[2] = '{128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 16'h8000, 16'h7FFF, 16'h0000};
        tbl[3] = '{128'hA5A5A5A55A5A5A5AC3C3C3C33C3C3C3C, 16'hBEEF, 16'hCAFE, 16'hFFFF};
        tbl[4] = '{128'h13579BDF02468ACE13579BDF02468ACE, 16'h0F0F, 16'hF0F0, 16'h8001};

        reset = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_challenge = '0;
        req_a = '0;
        req_b = '0;
        puf_response = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_rsp_data", 128'(rsp_data), 128'(0));
        chk("rst_trigger", 128'(puf_trigger), 128'(0));
        chk("rst_puf_reset", 128'(puf_reset), 128'(0));
        chk("rst_challenge", puf_challenge, 128'(0));
        chk("rst_a", 128'(puf_a), 128'(0));
        chk("rst_b", 128'(puf_b), 128'(0));
        reset = 1'b0;
        @(posedge clk); #1;
        chk("req_ready_after_rst", 128'(req_ready), 128'(1));

        // Single evaluation with a stray request during FIRE and noise in RELEASE
        ch1 = 128'h0123456789ABCDEF0123456789ABCDEF;
        push_single(16'hA5C3);
        issue(ch1, 16'h1234, 16'h00FF, acc);
        chk("t1_puf_a", 128'(puf_a), 128'(16'h1234));
        chk("t1_puf_b", 128'(puf_b), 128'(16'h00FF));
        timed(ch1, 1'b1);
        chk("t1_rsp_data", 128'(rsp_data), 128'(16'hA5C3));

        // Backpressure: held for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_rsp_valid", 128'(rsp_valid), 128'(1));
            chk("bp_rsp_data", 128'(rsp_data), 128'(16'hA5C3));
            chk("bp_req_ready", 128'(req_ready), 128'(0));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("hs_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("hs_req_ready", 128'(req_ready), 128'(1));
        chk("hs_cycle", 128'(last_hs), 128'(cyc));

        // Reset in the middle of FIRE
        push_single(16'h1111);
        issue(128'hDEADBEEF, 16'h0003, 16'h0004, acc);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
        end
        chk("mid_fire_trigger", 128'(puf_trigger), 128'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_q.delete();
        sb_q.delete();
        chk("abort_trigger", 128'(puf_trigger), 128'(0));
        chk("abort_puf_reset", 128'(puf_reset), 128'(0));
        chk("abort_rsp_valid", 128'(rsp_valid), 128'(0));
        @(posedge clk); #1;
        chk("abort_req_ready", 128'(req_ready), 128'(1));

        ch2 = 128'hCAFEF00D_00000000_11111111_22222222;
        push_single(16'h5A3C);
        issue(ch2, 16'h00AA, 16'h0055, acc);
        timed(ch2, 1'b0);
        chk("post_abort_rsp", 128'(rsp_data), 128'(16'h5A3C));
        rsp_ready = 1'b1;
        @(posedge clk); #1;

        // Back-to-back table with rsp_ready held high
        for (int i = 0; i < 5; i++) begin
            push_single(tbl[i].resp);
            issue(tbl[i].ch, tbl[i].a, tbl[i].b, acc);
            if (i > 0) chk($sformatf("b2b_accept[%0d]", i), 128'(acc), 128'(last_hs + 1));
            chk($sformatf("tbl_challenge[%0d]", i), puf_challenge, tbl[i].ch);
            chk($sformatf("tbl_a[%0d]", i), 128'(puf_a), 128'(tbl[i].a));
            chk($sformatf("tbl_b[%0d]", i), 128'(puf_b), 128'(tbl[i].b));
            n = 0;
            while (!rsp_valid && n < LAT + 10) begin
                @(posedge clk); #1;
                n++;
            end
            chk($sformatf("tbl_latency[%0d]", i), 128'(n), 128'(LAT));
            chk($sformatf("tbl_rsp[%0d]", i), 128'(rsp_data), 128'(tbl[i].resp));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;

`ifdef PUF_MAJORITY_VOTE_EN
        // Majority of mixed votes
        model_q.push_back(16'h000F);
        model_q.push_back(16'h000F);
        model_q.push_back(16'h00F0);
        model_q.push_back(16'h000F);
        model_q.push_back(16'h00FF);
        sb_q.push_back(16'h000F);
        issue(128'h55, 16'h0101, 16'h0202, acc);
        n = 0;
        while (!rsp_valid && n < LAT + 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("vote_latency", 128'(n), 128'(121));
        chk("vote_rsp", 128'(rsp_data), 128'(16'h000F));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 128'(sb_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
